// File: rtl/barrel_math.sv
// Barrel-distortion address math: scans the output raster, feeds a translate and a
// rotate CORDIC through AXI-style handshakes and emits the distorted source address.
module barrel_math #(
    parameter int                 IMG_W = 1920,
    parameter int                 IMG_H = 1080,
    parameter logic signed [15:0] K     = 16'sd0
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] tIn_tdata,
    output logic        tIn_tvalid,
    input  logic        tIn_tready,
    input  logic [31:0] tOut_tdata,
    input  logic        tOut_tvalid,
    output logic        tOut_tready,
    output logic [31:0] rCin_tdata,
    output logic        rCin_tvalid,
    output logic        rPin_tvalid,
    input  logic        rCin_tready,
    input  logic        rPin_tready,
    output logic [15:0] rPin_tdata,
    input  logic [31:0] rOut_tdata,
    input  logic        rOut_tvalid,
    output logic        rOut_tready,
    output logic [11:0] xOut,
    output logic [11:0] yOut,
    output logic        addr_vld,
    input  logic        mem_ready
);

    logic [11:0]        xIn, yIn, xIn_d, yIn_d;
    logic signed [15:0] phase;
    logic [15:0]        radius;
    logic signed [15:0] rsq2;

    logic               t_hs, r_hs;
    logic [15:0]        dx, dy;
    logic [9:0]         r2n;
    logic signed [31:0] k_term, rsq2_w;
    logic signed [47:0] rd_w;
    logic [15:0]        rdist;
    logic signed [15:0] xr, yr;
    logic signed [31:0] xs, ys;
    logic [11:0]        xOut_q, yOut_q, xOut_d, yOut_d;
    logic               addr_vld_q;

    // Valids/readies toward the cores are gated by reset so nothing leaks while held.
    assign tIn_tvalid  = mem_ready & reset;
    assign rOut_tready = mem_ready & reset;
    assign t_hs        = tIn_tvalid & tIn_tready;
    assign r_hs        = rOut_tvalid & rOut_tready;

    assign dx        = ({4'b0, xIn} - 16'(IMG_W / 2)) << 3;
    assign dy        = ({4'b0, yIn} - 16'(IMG_H / 2)) << 3;
    assign tIn_tdata = {dy, dx};

    assign radius = tOut_tdata[15:0];
    assign phase  = tOut_tdata[31:16];

    assign rCin_tvalid = tOut_tvalid;
    assign rPin_tvalid = tOut_tvalid;
    assign tOut_tready = rCin_tready & rPin_tready;
    assign rCin_tdata  = {16'd0, rdist};
    assign rPin_tdata  = phase;

    always_comb begin
        r2n    = 10'((32'(radius) * 32'(radius)) >> 22);
        k_term = (32'(K) * $signed({22'b0, r2n})) >>> 4;
        rsq2_w = k_term + 32'sd16;
        if (rsq2_w > 32'sd32767)       rsq2 = 16'sh7fff;
        else if (rsq2_w < -32'sd32768) rsq2 = 16'sh8000;
        else                           rsq2 = 16'(rsq2_w);
        rd_w = ($signed({32'b0, radius}) * 48'(rsq2)) >>> 4;
        if (rd_w < 48'sd0)            rdist = '0;
        else if (rd_w > 48'sd32767)   rdist = 16'd32767;
        else                          rdist = 16'(rd_w);
    end

    always_comb begin
        xIn_d = xIn;
        yIn_d = yIn;
        if (t_hs) begin
            if (xIn == 12'(IMG_W - 1)) begin
                xIn_d = '0;
                yIn_d = (yIn == 12'(IMG_H - 1)) ? '0 : yIn + 12'd1;
            end else begin
                xIn_d = xIn + 12'd1;
            end
        end
    end

    // Rotated Q3 coordinates back to pixel space, clamped to the image.
    assign xr = rOut_tdata[15:0];
    assign yr = rOut_tdata[31:16];
    always_comb begin
        xs     = 32'(xr >>> 3) + 32'(IMG_W / 2);
        ys     = 32'(yr >>> 3) + 32'(IMG_H / 2);
        xOut_d = xOut_q;
        yOut_d = yOut_q;
        if (r_hs) begin
            if (xs < 32'sd0)                 xOut_d = '0;
            else if (xs > 32'(IMG_W - 1))    xOut_d = 12'(IMG_W - 1);
            else                             xOut_d = 12'(xs);
            if (ys < 32'sd0)                 yOut_d = '0;
            else if (ys > 32'(IMG_H - 1))    yOut_d = 12'(IMG_H - 1);
            else                             yOut_d = 12'(ys);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            xIn        <= '0;
            yIn        <= '0;
            xOut_q     <= '0;
            yOut_q     <= '0;
            addr_vld_q <= 1'b0;
        end else begin
            xIn        <= xIn_d;
            yIn        <= yIn_d;
            xOut_q     <= xOut_d;
            yOut_q     <= yOut_d;
            addr_vld_q <= r_hs;
        end
    end

    assign xOut     = xOut_q;
    assign yOut     = yOut_q;
    assign addr_vld = addr_vld_q;

endmodule

// File: tb/tb_barrel_math.sv
// Bench for barrel_math: a full-size instance (K=16) and a tiny 8x4 instance (K=-1000)
// share stimulus; results are compared against an arithmetic reference model.
module tb_barrel_math;

    localparam int AW = 1920, AH = 1080, SW = 8, SH = 4;
    localparam int KA = 16, KS = -1000;

    logic        clk = 1'b0;
    logic        reset, mem_ready, tIn_tready, tOut_tvalid, rCin_tready, rPin_tready, rOut_tvalid;
    logic [31:0] tOut_tdata, rOut_tdata;

    logic [31:0] tIn_tdata_a, rCin_tdata_a, tIn_tdata_s, rCin_tdata_s;
    logic [15:0] rPin_tdata_a, rPin_tdata_s;
    logic [11:0] xOut_a, yOut_a, xOut_s, yOut_s;
    logic        tIn_tvalid_a, tOut_tready_a, rCin_tvalid_a, rPin_tvalid_a, rOut_tready_a, addr_vld_a;
    logic        tIn_tvalid_s, tOut_tready_s, rCin_tvalid_s, rPin_tvalid_s, rOut_tready_s, addr_vld_s;

    always #5 clk = ~clk;

    barrel_math #(.IMG_W(AW), .IMG_H(AH), .K(16'sd16)) dut_a (
        .clk(clk), .reset(reset),
        .tIn_tdata(tIn_tdata_a), .tIn_tvalid(tIn_tvalid_a), .tIn_tready(tIn_tready),
        .tOut_tdata(tOut_tdata), .tOut_tvalid(tOut_tvalid), .tOut_tready(tOut_tready_a),
        .rCin_tdata(rCin_tdata_a), .rCin_tvalid(rCin_tvalid_a), .rPin_tvalid(rPin_tvalid_a),
        .rCin_tready(rCin_tready), .rPin_tready(rPin_tready), .rPin_tdata(rPin_tdata_a),
        .rOut_tdata(rOut_tdata), .rOut_tvalid(rOut_tvalid), .rOut_tready(rOut_tready_a),
        .xOut(xOut_a), .yOut(yOut_a), .addr_vld(addr_vld_a), .mem_ready(mem_ready)
    );

    barrel_math #(.IMG_W(SW), .IMG_H(SH), .K(-16'sd1000)) dut_s (
        .clk(clk), .reset(reset),
        .tIn_tdata(tIn_tdata_s), .tIn_tvalid(tIn_tvalid_s), .tIn_tready(tIn_tready),
        .tOut_tdata(tOut_tdata), .tOut_tvalid(tOut_tvalid), .tOut_tready(tOut_tready_s),
        .rCin_tdata(rCin_tdata_s), .rCin_tvalid(rCin_tvalid_s), .rPin_tvalid(rPin_tvalid_s),
        .rCin_tready(rCin_tready), .rPin_tready(rPin_tready), .rPin_tdata(rPin_tdata_s),
        .rOut_tdata(rOut_tdata), .rOut_tvalid(rOut_tvalid), .rOut_tready(rOut_tready_s),
        .xOut(xOut_s), .yOut(yOut_s), .addr_vld(addr_vld_s), .mem_ready(mem_ready)
    );

    int passed = 0, total = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: plain integer arithmetic with floor division.
    function automatic longint fdiv(longint a, longint d);
        if (a >= 0) return a / d;
        return -((-a + d - 1) / d);
    endfunction

    function automatic longint ref_rsq2(longint k, longint r);
        longint v;
        v = 16 + fdiv(k * ((r * r) / 4194304), 16);
        if (v > 32767) v = 32767;
        if (v < -32768) v = -32768;
        return v;
    endfunction

    function automatic longint ref_rdist(longint k, longint r);
        longint v;
        v = fdiv(r * ref_rsq2(k, r), 16);
        if (v < 0) v = 0;
        if (v > 32767) v = 32767;
        return v;
    endfunction

    function automatic longint ref_coord(longint v, longint dim);
        longint q;
        q = fdiv(v, 8) + dim / 2;
        if (q < 0) q = 0;
        if (q > dim - 1) q = dim - 1;
        return q;
    endfunction

    function automatic longint ref_tin(longint n, longint w, longint h);
        longint x, y, dxv, dyv;
        x   = n % w;
        y   = (n / w) % h;
        dxv = ((x - w / 2) * 8) & 'h0000FFFF;
        dyv = ((y - h / 2) * 8) & 'h0000FFFF;
        return (dyv << 16) | dxv;
    endfunction

    typedef struct { int radius; int phase; int rd_a; int rq_a; int rd_s; int rq_s; } rot_vec_t;
    typedef struct { int xr; int yr; int xa; int ya; int xs; int ys; } out_vec_t;

    rot_vec_t rv[5];
    out_vec_t ov[7];

    longint n, exa, eya, exs, eys;
    logic   ths, rhs;
    int     bad;
    logic signed [15:0] vx, vy;
    logic [15:0] rad;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", passed, total);
        $fatal(1);
    end

    initial begin
        rv[0] = '{8192, 1234, 16384, 32, 0, -984};
        rv[1] = '{0, -5, 0, 16, 0, 16};
        rv[2] = '{65535, 32767, 32767, 1039, 0, -32768};
        rv[3] = '{4096, -32768, 5120, 20, 0, -234};
        rv[4] = '{1000, 77, 1000, 16, 1000, 16};

        ov[0] = '{0, 0, 960, 540, 4, 2};
        ov[1] = '{-7680, -4320, 0, 0, 0, 0};
        ov[2] = '{-1, -1, 959, 539, 3, 1};
        ov[3] = '{32767, 32767, 1919, 1079, 7, 3};
        ov[4] = '{-32768, -32768, 0, 0, 0, 0};
        ov[5] = '{100, -100, 972, 527, 7, 0};
        ov[6] = '{-24, 8, 957, 541, 1, 3};

        reset = 1'b0; mem_ready = 1'b1; tIn_tready = 1'b1; tOut_tvalid = 1'b0;
        tOut_tdata = '0; rCin_tready = 1'b0; rPin_tready = 1'b0; rOut_tvalid = 1'b1; rOut_tdata = '0;

        // Reset held with mem_ready high: outputs must stay quiet.
        repeat (10) tick();
        chk("rst_tIn_tvalid_a", tIn_tvalid_a, 0);
        chk("rst_tIn_tvalid_s", tIn_tvalid_s, 0);
        chk("rst_rOut_tready_a", rOut_tready_a, 0);
        chk("rst_xIn_a", dut_a.xIn, 0);
        chk("rst_yIn_a", dut_a.yIn, 0);
        chk("rst_xOut_a", xOut_a, 0);
        chk("rst_yOut_a", yOut_a, 0);
        chk("rst_addr_vld_a", addr_vld_a, 0);

        // Released but memory not ready for 25 cycles.
        mem_ready = 1'b0; reset = 1'b1; bad = 0;
        repeat (25) begin
            tick();
            if (tIn_tvalid_a || tIn_tvalid_s || addr_vld_a || addr_vld_s ||
                dut_a.xIn != 0 || dut_a.yIn != 0) bad++;
        end
        chk("idle_stall_events", bad, 0);
        chk("tIn_tdata_a_origin", tIn_tdata_a, ref_tin(0, AW, AH));
        chk("tIn_tdata_s_origin", tIn_tdata_s, ref_tin(0, SW, SH));

        // Translate-to-rotate math vectors.
        for (int i = 0; i < 5; i++) begin
            tOut_tdata = {16'(rv[i].phase), 16'(rv[i].radius)};
            #1;
            chk($sformatf("rdist_a[%0d]", i), rCin_tdata_a, rv[i].rd_a);
            chk($sformatf("rsq2_a[%0d]", i), dut_a.rsq2, rv[i].rq_a);
            chk($sformatf("rdist_s[%0d]", i), rCin_tdata_s, rv[i].rd_s);
            chk($sformatf("rsq2_s[%0d]", i), dut_s.rsq2, rv[i].rq_s);
            chk($sformatf("rPin_a[%0d]", i), rPin_tdata_a, rv[i].phase & 'hFFFF);
            chk($sformatf("phase_a[%0d]", i), dut_a.phase, rv[i].phase);
            chk($sformatf("radius_a[%0d]", i), dut_a.radius, rv[i].radius);
        end

        for (int m = 0; m < 8; m++) begin
            logic [2:0] mb;
            mb = 3'(m);
            {tOut_tvalid, rCin_tready, rPin_tready} = mb;
            #1;
            chk($sformatf("rCin_tvalid[%0d]", m), rCin_tvalid_a, mb[2]);
            chk($sformatf("rPin_tvalid[%0d]", m), rPin_tvalid_a, mb[2]);
            chk($sformatf("tOut_tready[%0d]", m), tOut_tready_a, mb[1] & mb[0]);
        end

        // Rotate result to address, one strobe per handshake, hold afterwards.
        tIn_tready = 1'b0; mem_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            rOut_tdata = {16'(ov[i].yr), 16'(ov[i].xr)};
            rOut_tvalid = 1'b1;
            #1;
            chk($sformatf("rOut_tready[%0d]", i), rOut_tready_a, 1);
            tick();
            chk($sformatf("addr_vld_hi[%0d]", i), addr_vld_a, 1);
            chk($sformatf("xOut_a[%0d]", i), xOut_a, ov[i].xa);
            chk($sformatf("yOut_a[%0d]", i), yOut_a, ov[i].ya);
            chk($sformatf("xOut_s[%0d]", i), xOut_s, ov[i].xs);
            chk($sformatf("yOut_s[%0d]", i), yOut_s, ov[i].ys);
            rOut_tvalid = 1'b0;
            rOut_tdata = $urandom;
            tick();
            chk($sformatf("addr_vld_lo[%0d]", i), addr_vld_a, 0);
            chk($sformatf("xOut_hold[%0d]", i), xOut_a, ov[i].xa);
            chk($sformatf("yOut_hold[%0d]", i), yOut_s, ov[i].ys);
            exa = ov[i].xa; eya = ov[i].ya; exs = ov[i].xs; eys = ov[i].ys;
        end
        chk("xIn_untouched", dut_a.xIn, 0);

        // Randomised stream with stalls on every interface.
        n = 0;
        for (int c = 0; c < 400; c++) begin
            mem_ready   = ($urandom_range(0, 3) != 0);
            tIn_tready  = 1'($urandom_range(0, 1));
            rOut_tvalid = 1'($urandom_range(0, 1));
            rOut_tdata  = $urandom;
            rad         = 16'($urandom_range(0, 65535) >> $urandom_range(0, 6));
            tOut_tdata  = {16'($urandom), rad};
            {tOut_tvalid, rCin_tready, rPin_tready} = 3'($urandom_range(0, 7));
            #1;
            chk("rnd_tIn_tvalid", tIn_tvalid_a, mem_ready);
            chk("rnd_rOut_tready", rOut_tready_s, mem_ready);
            chk("rnd_tIn_tdata_a", tIn_tdata_a, ref_tin(n, AW, AH));
            chk("rnd_tIn_tdata_s", tIn_tdata_s, ref_tin(n, SW, SH));
            chk("rnd_rdist_a", rCin_tdata_a, ref_rdist(KA, rad));
            chk("rnd_rdist_s", rCin_tdata_s, ref_rdist(KS, rad));
            chk("rnd_tOut_tready", tOut_tready_s, rCin_tready & rPin_tready);
            ths = mem_ready & tIn_tready;
            rhs = mem_ready & rOut_tvalid;
            if (rhs) begin
                vx = rOut_tdata[15:0];
                vy = rOut_tdata[31:16];
                exa = ref_coord(vx, AW); eya = ref_coord(vy, AH);
                exs = ref_coord(vx, SW); eys = ref_coord(vy, SH);
            end
            tick();
            n += longint'(ths);
            chk("rnd_xIn_a", dut_a.xIn, n % AW);
            chk("rnd_yIn_a", dut_a.yIn, (n / AW) % AH);
            chk("rnd_xIn_s", dut_s.xIn, n % SW);
            chk("rnd_yIn_s", dut_s.yIn, (n / SW) % SH);
            chk("rnd_addr_vld", addr_vld_a, rhs);
            chk("rnd_xOut_a", xOut_a, exa);
            chk("rnd_yOut_a", yOut_a, eya);
            chk("rnd_xOut_s", xOut_s, exs);
            chk("rnd_yOut_s", yOut_s, eys);
        end

        // Complete one full line of the large image.
        mem_ready = 1'b1; tIn_tready = 1'b1; rOut_tvalid = 1'b0;
        while (n < 1920) begin
            tick();
            n++;
        end
        chk("line_wrap_xIn_a", dut_a.xIn, 0);
        chk("line_wrap_yIn_a", dut_a.yIn, 1);
        chk("frame_wrap_xIn_s", dut_s.xIn, 0);
        chk("frame_wrap_yIn_s", dut_s.yIn, 0);

        // Five-cycle memory stall mid-stream, then resume.
        mem_ready = 1'b0; rOut_tvalid = 1'b1; rOut_tdata = {16'd800, 16'd800};
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("stall_tIn_tvalid", tIn_tvalid_a, 0);
            chk("stall_rOut_tready", rOut_tready_a, 0);
            tick();
            chk("stall_xIn_a", dut_a.xIn, 0);
            chk("stall_addr_vld", addr_vld_a, 0);
            chk("stall_xOut_a", xOut_a, exa);
            chk("stall_yOut_s", yOut_s, eys);
        end
        mem_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            n++;
            chk("resume_xIn_a", dut_a.xIn, n % AW);
            chk("resume_yIn_a", dut_a.yIn, (n / AW) % AH);
            chk("resume_xIn_s", dut_s.xIn, n % SW);
            chk("resume_addr_vld", addr_vld_a, 1);
            chk("resume_xOut_a", xOut_a, 1060);
            chk("resume_yOut_a", yOut_a, 640);
        end

        // Asynchronous reset mid-stream.
        reset = 1'b0;
        #1;
        chk("midrst_xIn_a", dut_a.xIn, 0);
        chk("midrst_yIn_a", dut_a.yIn, 0);
        chk("midrst_addr_vld", addr_vld_a, 0);
        chk("midrst_xOut_a", xOut_a, 0);
        chk("midrst_tIn_tvalid", tIn_tvalid_a, 0);
        chk("midrst_rOut_tready", rOut_tready_a, 0);
        tick();
        reset = 1'b1; rOut_tvalid = 1'b0; n = 0;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("restart_tIn_tdata_a", tIn_tdata_a, ref_tin(n, AW, AH));
            tick();
            n++;
            chk("restart_xIn_a", dut_a.xIn, n);
            chk("restart_yIn_a", dut_a.yIn, 0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
